// File: rtl/fifo_dualclock_macro_pkg.sv
// Shared depth/width helpers and legal parameter strings for the FIFO macro.
package fifo_dualclock_macro_pkg;

   localparam string DEVICE_7SERIES = "7SERIES";
   localparam string SIZE_18KB      = "18Kb";
   localparam string SIZE_36KB      = "36Kb";
   localparam string STR_TRUE       = "TRUE";
   localparam string STR_FALSE      = "FALSE";

   // Word depth of one primitive for a given width; the 18Kb primitive is half the 36Kb one.
   function automatic int unsigned depth(input int unsigned width, input bit is_36k);
      int unsigned d;
      if (width > 36)      d = 512;
      else if (width > 18) d = 1024;
      else if (width > 9)  d = 2048;
      else if (width > 4)  d = 4096;
      else                 d = 8192;
      return is_36k ? d : d / 2;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned d);
      return $clog2(d);
   endfunction

endpackage

// File: rtl/fifo_dualclock_macro_if.sv
// Data/flag bundle between a FIFO user (master) and the FIFO macro (slave).
interface fifo_dualclock_macro_if
   import fifo_dualclock_macro_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int CW         = 12
) ();

   logic [DATA_WIDTH-1:0] DI;
   logic                  WREN;
   logic                  RDEN;
   logic [DATA_WIDTH-1:0] DO;
   logic                  EMPTY;
   logic                  FULL;
   logic                  ALMOSTEMPTY;
   logic                  ALMOSTFULL;
   logic [CW-1:0]         RDCOUNT;
   logic [CW-1:0]         WRCOUNT;
   logic                  RDERR;
   logic                  WRERR;

   modport master (
      output DI, WREN, RDEN,
      input  DO, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, RDCOUNT, WRCOUNT, RDERR, WRERR
   );

   modport slave (
      input  DI, WREN, RDEN,
      output DO, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, RDCOUNT, WRCOUNT, RDERR, WRERR
   );

endinterface

// File: rtl/fifo_dualclock_macro_ram.sv
// Simple dual-port RAM: synchronous write, registered read that holds when rd_en is low.
module fifo_dualclock_macro_ram
   import fifo_dualclock_macro_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4096,
   parameter int AW         = 12
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_dualclock_macro.sv
// Single-clock FIFO with the 7-series FIFO macro parameters, flags, pointers and error pulses.
module fifo_dualclock_macro
   import fifo_dualclock_macro_pkg::*;
#(
   parameter logic [12:0] ALMOST_EMPTY_OFFSET     = 13'h0010,
   parameter logic [12:0] ALMOST_FULL_OFFSET      = 13'h0010,
   parameter int          DATA_WIDTH              = 4,
   parameter string       DEVICE                  = "7SERIES",
   parameter string       FIFO_SIZE               = "18Kb",
   parameter string       FIRST_WORD_FALL_THROUGH = "FALSE"
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   fifo_dualclock_macro_if.slave   bus
);

   localparam int unsigned DEPTH = depth(DATA_WIDTH, FIFO_SIZE == SIZE_36KB);
   localparam int          CW    = cnt_width(DEPTH);
   localparam bit          FWFT  = (FIRST_WORD_FALL_THROUGH == STR_TRUE);

   localparam logic [CW:0] OCC_FULL = (CW+1)'(DEPTH);
   localparam logic [CW:0] AE_LIM   = (CW+1)'(ALMOST_EMPTY_OFFSET);
   localparam logic [CW:0] AF_LIM   = (CW+1)'(DEPTH - ALMOST_FULL_OFFSET);

   if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_width
      $error("fifo_dualclock_macro: DATA_WIDTH must be 1..72");
   end
   if (DATA_WIDTH > 36 && FIFO_SIZE == SIZE_18KB) begin : g_bad_width_18k
      $error("fifo_dualclock_macro: DATA_WIDTH above 36 needs FIFO_SIZE 36Kb");
   end
   if (DEVICE != DEVICE_7SERIES) begin : g_bad_device
      $error("fifo_dualclock_macro: DEVICE must be 7SERIES");
   end
   if (FIFO_SIZE != SIZE_18KB && FIFO_SIZE != SIZE_36KB) begin : g_bad_size
      $error("fifo_dualclock_macro: FIFO_SIZE must be 18Kb or 36Kb");
   end
   if (FIRST_WORD_FALL_THROUGH != STR_TRUE && FIRST_WORD_FALL_THROUGH != STR_FALSE) begin : g_bad_fwft
      $error("fifo_dualclock_macro: FIRST_WORD_FALL_THROUGH must be TRUE or FALSE");
   end
   if (ALMOST_EMPTY_OFFSET >= DEPTH || ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_offset
      $error("fifo_dualclock_macro: almost offsets must be below DEPTH");
   end

   logic [CW:0]           occ_q, occ_d;
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  aempty_q, aempty_d;
   logic                  afull_q, afull_d;
   logic                  wrerr_q, wrerr_d;
   logic                  rderr_q, rderr_d;
   logic                  byp_q, byp_d;
   logic                  zero_q, zero_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_rd_en;
   logic [CW-1:0]         ram_rd_addr;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   always_comb begin
      wr_acc   = RST_N && bus.WREN && !full_q;
      rd_acc   = RST_N && bus.RDEN && !empty_q;
      occ_d    = occ_q + (CW+1)'(wr_acc) - (CW+1)'(rd_acc);
      wr_ptr_d = wr_ptr_q + CW'(wr_acc);
      rd_ptr_d = rd_ptr_q + CW'(rd_acc);
      empty_d  = (occ_d == '0);
      full_d   = (occ_d == OCC_FULL);
      aempty_d = (occ_d <= AE_LIM);
      afull_d  = (occ_d >= AF_LIM);
      wrerr_d  = bus.WREN && full_q;
      rderr_d  = bus.RDEN && empty_q;
      // In FWFT the RAM cannot return a word written on this same edge, so
      // a write that becomes the new head is shown from the bypass register.
      byp_d      = FWFT && wr_acc && (occ_q == (CW+1)'(rd_acc));
      byp_data_d = wr_acc ? bus.DI : byp_data_q;
      zero_d     = zero_q && !(FWFT ? wr_acc : rd_acc);
      // FWFT prefetches the post-edge head every cycle; standard mode reads only on a pop.
      ram_rd_en   = FWFT ? 1'b1 : rd_acc;
      ram_rd_addr = FWFT ? rd_ptr_d : rd_ptr_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         wrerr_q  <= 1'b0;
         rderr_q  <= 1'b0;
         byp_q    <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         wrerr_q  <= wrerr_d;
         rderr_q  <= rderr_d;
         byp_q    <= byp_d;
         zero_q   <= zero_d;
      end
   end

   always_ff @(posedge CLK) begin
      byp_data_q <= byp_data_d;
   end

   fifo_dualclock_macro_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (CW)
   ) u_ram (
      .clk     (CLK),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.DI),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   assign bus.DO          = zero_q ? '0 : (byp_q ? byp_data_q : ram_rd_data);
   assign bus.EMPTY       = empty_q;
   assign bus.FULL        = full_q;
   assign bus.ALMOSTEMPTY = aempty_q;
   assign bus.ALMOSTFULL  = afull_q;
   assign bus.WRCOUNT     = wr_ptr_q;
   assign bus.RDCOUNT     = rd_ptr_q;
   assign bus.WRERR       = wrerr_q;
   assign bus.RDERR       = rderr_q;

endmodule

// File: tb/tb_fifo_dualclock_macro.sv
// Scoreboard bench: a FWFT 18-bit/36Kb FIFO and a standard 4-bit/18Kb FIFO against a queue model.
module tb_fifo_dualclock_macro;

   localparam int DEPTH_A = 2048;
   localparam int DEPTH_B = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_dualclock_macro_if #(.DATA_WIDTH(18), .CW(11)) bus_a ();
   fifo_dualclock_macro_if #(.DATA_WIDTH(4),  .CW(12)) bus_b ();

   fifo_dualclock_macro #(
      .ALMOST_EMPTY_OFFSET     (13'd16),
      .ALMOST_FULL_OFFSET      (13'd16),
      .DATA_WIDTH              (18),
      .DEVICE                  ("7SERIES"),
      .FIFO_SIZE               ("36Kb"),
      .FIRST_WORD_FALL_THROUGH ("TRUE")
   ) dut_a (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_a.slave)
   );

   fifo_dualclock_macro #(
      .ALMOST_EMPTY_OFFSET     (13'd100),
      .ALMOST_FULL_OFFSET      (13'd200),
      .DATA_WIDTH              (4),
      .DEVICE                  ("7SERIES"),
      .FIFO_SIZE               ("18Kb"),
      .FIRST_WORD_FALL_THROUGH ("FALSE")
   ) dut_b (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_b.slave)
   );

   typedef struct packed {
      logic rst;
      logic wr_acc;
      logic rd_acc;
      logic wrerr;
      logic rderr;
      int   occ;
      int   wrc;
      int   rdc;
   } rec_t;

   rec_t        rec_q [2][$];
   logic [17:0] data_q[2][$];
   int          occ_m [2];
   int          wrc_m [2];
   int          rdc_m [2];
   int          depth_m[2] = '{DEPTH_A, DEPTH_B};
   int          ae_m   [2] = '{16, 100};
   int          af_m   [2] = '{16, 200};
   logic [17:0] last_do_b;

   bit          wr_i[2];
   bit          rd_i[2];
   logic [17:0] di_i[2];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   // Reference model: what each FIFO must hold after the coming edge.
   task automatic model(input int d, input bit rst);
      rec_t r;
      bit   wa, ra;
      r = '0;
      if (rst) begin
         data_q[d].delete();
         occ_m[d] = 0;
         wrc_m[d] = 0;
         rdc_m[d] = 0;
         r.rst = 1'b1;
      end else begin
         wa = wr_i[d] && (occ_m[d] < depth_m[d]);
         ra = rd_i[d] && (occ_m[d] > 0);
         r.wrerr  = wr_i[d] && (occ_m[d] == depth_m[d]);
         r.rderr  = rd_i[d] && (occ_m[d] == 0);
         r.wr_acc = wa;
         r.rd_acc = ra;
         if (wa) data_q[d].push_back((d == 1) ? {14'd0, di_i[1][3:0]} : di_i[0]);
         occ_m[d] = occ_m[d] + int'(wa) - int'(ra);
         wrc_m[d] = (wrc_m[d] + int'(wa)) % depth_m[d];
         rdc_m[d] = (rdc_m[d] + int'(ra)) % depth_m[d];
      end
      r.occ = occ_m[d];
      r.wrc = wrc_m[d];
      r.rdc = rdc_m[d];
      rec_q[d].push_back(r);
   endtask

   task automatic cycle(input bit rst);
      @(negedge clk);
      rst_n      = !rst;
      bus_a.WREN = wr_i[0];
      bus_a.RDEN = rd_i[0];
      bus_a.DI   = di_i[0];
      bus_b.WREN = wr_i[1];
      bus_b.RDEN = rd_i[1];
      bus_b.DI   = di_i[1][3:0];
      model(0, rst);
      model(1, rst);
   endtask

   task automatic set_all(input bit w, input bit r, input logic [17:0] v);
      for (int d = 0; d < 2; d++) begin
         wr_i[d] = w;
         rd_i[d] = r;
         di_i[d] = v;
      end
   endtask

   task automatic monitor_step(input int d);
      rec_t        r;
      logic [31:0] s_do;
      logic        s_e, s_f, s_ae, s_af, s_we, s_re;
      logic [31:0] s_wc, s_rc;
      if (rec_q[d].size() == 0) return;
      r = rec_q[d].pop_front();
      if (d == 0) begin
         s_do = 32'(bus_a.DO);   s_e  = bus_a.EMPTY;       s_f  = bus_a.FULL;
         s_ae = bus_a.ALMOSTEMPTY; s_af = bus_a.ALMOSTFULL;
         s_we = bus_a.WRERR;     s_re = bus_a.RDERR;
         s_wc = 32'(bus_a.WRCOUNT); s_rc = 32'(bus_a.RDCOUNT);
      end else begin
         s_do = 32'(bus_b.DO);   s_e  = bus_b.EMPTY;       s_f  = bus_b.FULL;
         s_ae = bus_b.ALMOSTEMPTY; s_af = bus_b.ALMOSTFULL;
         s_we = bus_b.WRERR;     s_re = bus_b.RDERR;
         s_wc = 32'(bus_b.WRCOUNT); s_rc = 32'(bus_b.RDCOUNT);
      end
      check("empty",       d, 32'(s_e),  32'(r.occ == 0));
      check("full",        d, 32'(s_f),  32'(r.occ == depth_m[d]));
      check("almostempty", d, 32'(s_ae), 32'(r.occ <= ae_m[d]));
      check("almostfull",  d, 32'(s_af), 32'(r.occ >= depth_m[d] - af_m[d]));
      check("wrerr",       d, 32'(s_we), 32'(r.wrerr));
      check("rderr",       d, 32'(s_re), 32'(r.rderr));
      check("wrcount",     d, s_wc, 32'(r.wrc));
      check("rdcount",     d, s_rc, 32'(r.rdc));
      if (r.rst) begin
         if (d == 1) last_do_b = '0;
         check("do_reset", d, s_do, 32'd0);
      end else if (d == 0) begin
         if (r.rd_acc) void'(data_q[0].pop_front());
         if (r.occ > 0) check("do_fwft_head", d, s_do, 32'(data_q[0][0]));
      end else begin
         if (r.rd_acc) last_do_b = data_q[1].pop_front();
         check("do_std", d, s_do, 32'(last_do_b));
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         monitor_step(0);
         monitor_step(1);
      end
   end

   initial begin
      last_do_b  = '0;
      set_all(1'b0, 1'b0, 18'd0);
      bus_a.WREN = 1'b0; bus_a.RDEN = 1'b0; bus_a.DI = '0;
      bus_b.WREN = 1'b0; bus_b.RDEN = 1'b0; bus_b.DI = '0;

      repeat (3) cycle(1'b1);
      repeat (3) cycle(1'b0);

      // Fill past full on both FIFOs: sequential data, overflow pulses afterwards.
      for (int i = 0; i < DEPTH_B + 4; i++) begin
         set_all(1'b1, 1'b0, 18'(i + 1));
         cycle(1'b0);
      end
      // Drain past empty on both.
      for (int i = 0; i < DEPTH_B + 4; i++) begin
         set_all(1'b0, 1'b1, 18'd0);
         cycle(1'b0);
      end
      set_all(1'b0, 1'b0, 18'd0);
      repeat (2) cycle(1'b0);

      // Single word round trip, then idle so the standard-mode DO must hold.
      set_all(1'b1, 1'b0, 18'h0000A);
      cycle(1'b0);
      set_all(1'b0, 1'b1, 18'd0);
      cycle(1'b0);
      set_all(1'b0, 1'b0, 18'd0);
      repeat (3) cycle(1'b0);

      // Steady state at occupancy 5 with simultaneous read and write.
      for (int i = 0; i < 5; i++) begin
         set_all(1'b1, 1'b0, 18'($urandom));
         cycle(1'b0);
      end
      for (int i = 0; i < 100; i++) begin
         set_all(1'b1, 1'b1, 18'($urandom));
         cycle(1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         set_all(1'b0, 1'b1, 18'd0);
         cycle(1'b0);
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         for (int d = 0; d < 2; d++) begin
            wr_i[d] = ($urandom_range(0, 99) < 55);
            rd_i[d] = ($urandom_range(0, 99) < 45);
            di_i[d] = 18'($urandom);
         end
         cycle($urandom_range(0, 999) == 0);
      end

      // Reset with data stored, then a clean round trip.
      set_all(1'b0, 1'b0, 18'd0);
      repeat (2) cycle(1'b1);
      for (int i = 0; i < 300; i++) begin
         set_all(1'b1, 1'b0, 18'($urandom));
         cycle(1'b0);
      end
      set_all(1'b1, 1'b1, 18'h3FFFF);
      cycle(1'b1);
      for (int i = 0; i < 3; i++) begin
         set_all(1'b1, 1'b0, 18'(20 + i));
         cycle(1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         set_all(1'b0, 1'b1, 18'd0);
         cycle(1'b0);
      end
      set_all(1'b0, 1'b0, 18'd0);
      repeat (3) cycle(1'b0);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
